uart_prog_loader: RTL and testbench

- UART program/data loader that sits directly upstream of the memory's upgrade port (upg_wen_i/upg_adr_i/upg_dat_i/upg_done_i).
- Receives an 8N1 serial byte stream, frames it into 32-bit words, and writes them into instruction or data memory.
- Signals completion so the memory can hand its ports back to the CPU.

---
 rtl/uart_prog_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives an 8N1 UART byte stream and turns it into word writes on a
//   memory upgrade port. Stream format: sync byte (0x5A = instruction
//   memory, 0x5B = data memory), 16-bit little-endian word count N, then
//   N little-endian 32-bit words.
//
//   Optional build macro UPG_CHECKSUM_EN: when defined, a trailing byte
//   equal to the XOR of all count and data bytes must follow the data.
//   A mismatch sets the error flag and leaves done low.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   upg_rx_i    UART receive line (asynchronous, idle high)
//   upg_wen_o   one-cycle write strobe
//   upg_adr_o   {target, word index}; MSB 0 = instruction, 1 = data memory
//   upg_dat_o   write data, held until the next write
//   upg_done_o  transfer complete, held until the next sync byte
//   upg_err_o   sticky error (frame error, index overflow, bad checksum)
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upg_rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int              TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  // Words at or beyond this index do not fit the address field.
  localparam logic [16:0]     IDX_LIM   = 17'd1 << (ADDR_W - 1);

  // ---------------------------------------------------------------------
  // Receiver
  // byte_vld is a single-cycle pulse; byte_data is valid in that cycle
  // and stays put until the next byte completes, so it doubles as the
  // one-byte holding register. The protocol FSM never stalls, so there
  // is no ready path back to the receiver.
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_s3;
  logic [TW-1:0] tmr;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_vld;
  logic [7:0]    byte_data;
  logic          frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_state  <= R_IDLE;
      tmr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= upg_rx_i;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_state)
        R_IDLE: begin
          tmr <= '0;
          // Only a falling edge starts a frame, so a held-low line
          // (break) yields a single frame error rather than a stream.
          if (rx_s3 && !rx_s2) rx_state <= R_START;
        end
        R_START: begin
          if (tmr == HALF_LAST) begin
            tmr      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;  // glitch rejection
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        R_DATA: begin
          if (tmr == BIT_LAST) begin
            tmr   <= '0;
            shreg <= {rx_s2, shreg[7:1]};       // LSB arrives first
            if (bit_idx == 3'd7) rx_state <= R_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        R_STOP: begin
          if (tmr == BIT_LAST) begin
            tmr      <= '0;
            rx_state <= R_IDLE;
            if (rx_s2) begin
              byte_vld  <= 1'b1;
              byte_data <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------
`ifdef UPG_CHECKSUM_EN
  typedef enum logic [2:0] {P_IDLE, P_CNT_LO, P_CNT_HI, P_DATA, P_CHK, P_FINISH} p_state_t;
  logic [7:0] chk;
`else
  typedef enum logic [2:0] {P_IDLE, P_CNT_LO, P_CNT_HI, P_DATA, P_FINISH} p_state_t;
`endif

  p_state_t    state;
  logic        target;
  logic [15:0] cnt;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] part;    // first three bytes of the word being assembled

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= P_IDLE;
      target     <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      part       <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      upg_wen_o <= 1'b0;
      if (frame_err) begin
        // A bad frame abandons the transfer; any partial word is dropped.
        upg_err_o <= 1'b1;
        state     <= P_IDLE;
      end else begin
        unique case (state)
          P_IDLE: begin
            if (byte_vld && (byte_data == 8'h5A || byte_data == 8'h5B)) begin
              target     <= byte_data[0];
              upg_done_o <= 1'b0;
              upg_err_o  <= 1'b0;
              idx        <= '0;
              bcnt       <= '0;
              state      <= P_CNT_LO;
`ifdef UPG_CHECKSUM_EN
              chk        <= '0;
`endif
            end
          end
          P_CNT_LO: begin
            if (byte_vld) begin
              cnt[7:0] <= byte_data;
              state    <= P_CNT_HI;
`ifdef UPG_CHECKSUM_EN
              chk      <= chk ^ byte_data;
`endif
            end
          end
          P_CNT_HI: begin
            if (byte_vld) begin
              cnt[15:8] <= byte_data;
`ifdef UPG_CHECKSUM_EN
              chk       <= chk ^ byte_data;
`endif
              // An empty transfer finishes straight away: done rises on
              // the cycle after this byte.
              if ({byte_data, cnt[7:0]} == 16'd0) begin
                upg_done_o <= 1'b1;
                state      <= P_IDLE;
              end else begin
                state <= P_DATA;
              end
            end
          end
          P_DATA: begin
            if (byte_vld) begin
              bcnt <= bcnt + 2'd1;
`ifdef UPG_CHECKSUM_EN
              chk  <= chk ^ byte_data;
`endif
              unique case (bcnt)
                2'd0: part[7:0]   <= byte_data;
                2'd1: part[15:8]  <= byte_data;
                2'd2: part[23:16] <= byte_data;
                default: begin
                  if ({1'b0, idx} < IDX_LIM) begin
                    upg_wen_o <= 1'b1;
                    upg_adr_o <= {target, idx[ADDR_W-2:0]};
                    upg_dat_o <= {byte_data, part};
                  end else begin
                    upg_err_o <= 1'b1;   // consumed but not written
                  end
                  idx <= idx + 16'd1;
                  if (idx + 16'd1 == cnt) begin
`ifdef UPG_CHECKSUM_EN
                    state <= P_CHK;
`else
                    state <= P_FINISH;
`endif
                  end
                end
              endcase
            end
          end
`ifdef UPG_CHECKSUM_EN
          P_CHK: begin
            if (byte_vld) begin
              if (byte_data == chk) begin
                state <= P_FINISH;
              end else begin
                upg_err_o <= 1'b1;
                state     <= P_IDLE;
              end
            end
          end
`endif
          P_FINISH: begin
            // Entered in the cycle the last strobe is issued, so done
            // rises one cycle after the final write.
            upg_done_o <= 1'b1;
            state      <= P_IDLE;
          end
          default: state <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 5;
  localparam int LIM    = 1 << (ADDR_W - 1);
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              upg_err_o;

  int vectors = 0;
  int fails   = 0;

  logic [W-1:0] exp_q[$];   // expected {adr, dat} writes, in order
  logic [7:0]   tx_q[$];    // byte stream for the current load

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .upg_rx_i   (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .upg_err_o  (upg_err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (upg_wen_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got adr %0h dat %0h expected no write", upg_adr_o, upg_dat_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({upg_adr_o, upg_dat_o} !== e) begin
          fails++;
          $display("FAIL write: got %0h expected %0h", {upg_adr_o, upg_dat_o}, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling clock edge; returns at a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic int sync_pos();
    int p = 0;
    while (p < tx_q.size() && tx_q[p] != 8'h5A && tx_q[p] != 8'h5B) p++;
    return p;
  endfunction

  task automatic append_checksum();
`ifdef UPG_CHECKSUM_EN
    int p;
    int n;
    logic [7:0] x;
    p = sync_pos();
    n = int'(tx_q[p+1]) + 256 * int'(tx_q[p+2]);
    x = 8'h00;
    for (int k = p + 1; k < tx_q.size(); k++) x ^= tx_q[k];
    if (n != 0) tx_q.push_back(x);
`endif
  endtask

  // Reference model: parse the stream as a loader would and list the writes.
  task automatic model_expect(output logic e_done, output logic e_err);
    int p;
    int n;
    logic t;
    p = sync_pos();
    t = tx_q[p][0];
    n = int'(tx_q[p+1]) + 256 * int'(tx_q[p+2]);
    e_err = 1'b0;
    for (int w = 0; w < n; w++) begin
      int b;
      logic [31:0] word;
      b = p + 3 + 4 * w;
      word = {tx_q[b+3], tx_q[b+2], tx_q[b+1], tx_q[b]};
      if (w < LIM) exp_q.push_back({t, (ADDR_W-1)'(w), word});
      else         e_err = 1'b1;
    end
    e_done = 1'b1;
  endtask

  task automatic gen_load(input int n);
    tx_q.delete();
    repeat ($urandom_range(0, 2)) begin
      logic [7:0] g;
      g = 8'($urandom_range(0, 255));
      if (g == 8'h5A || g == 8'h5B) g = 8'h00;
      tx_q.push_back(g);
    end
    tx_q.push_back(8'h5A | 8'($urandom_range(0, 1)));
    tx_q.push_back(8'(n));
    tx_q.push_back(8'(n >> 8));
    repeat (4 * n) tx_q.push_back(8'($urandom));
  endtask

  task automatic run_load(input logic e_done, input logic e_err);
    int p;
    p = sync_pos();
    for (int k = 0; k < tx_q.size(); k++) begin
      send_byte(tx_q[k], 1'b1);
      if (k == p) begin
        check("sync_clears_done", 64'(upg_done_o), 64'd0);
        check("sync_clears_err",  64'(upg_err_o),  64'd0);
      end
    end
    repeat (4) @(negedge clk);
    check("done", 64'(upg_done_o), 64'(e_done));
    check("err",  64'(upg_err_o),  64'(e_err));
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic random_load(input int n);
    logic ed, ee;
    gen_load(n);
    model_expect(ed, ee);
    append_checksum();
    run_load(ed, ee);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [95:0]  bytes;   // byte k in bits [8k+7:8k]
    int           len;
    int           nw;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic         done;
    logic         err;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{96'h00_DE_AD_BE_EF_12_34_56_78_00_02_5A, 11, 2,
               {5'h00, 32'h12345678}, {5'h01, 32'hDEADBEEF}, 1'b1, 1'b0};
    tbl[1] = '{96'h00_00_00_01_00_01_5B, 7, 1,
               {5'h10, 32'h00000001}, '0, 1'b1, 1'b0};
    tbl[2] = '{96'h00_00_5A, 3, 0, '0, '0, 1'b1, 1'b0};
    tbl[3] = '{96'hDD_CC_BB_AA_00_01_5B_33, 8, 1,
               {5'h10, 32'hDDCCBBAA}, '0, 1'b1, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o}), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      tx_q.delete();
      for (int k = 0; k < tbl[i].len; k++) tx_q.push_back(tbl[i].bytes[8*k +: 8]);
      if (tbl[i].nw > 0) exp_q.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) exp_q.push_back(tbl[i].w1);
      append_checksum();
      run_load(tbl[i].done, tbl[i].err);
    end

    // Randomized loads against the model.
    for (int i = 0; i < 5; i++) random_load($urandom_range(0, 3));

    // Frame error mid-transfer, then non-sync bytes must be ignored.
    tx_q = '{8'h5A, 8'h01, 8'h00};
    foreach (tx_q[k]) send_byte(tx_q[k], 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_err",  64'(upg_err_o),  64'd1);
    check("ferr_done", 64'(upg_done_o), 64'd0);
    repeat (4) send_byte(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr_err_held", 64'(upg_err_o), 64'd1);
    random_load(1);

    // Break: line low for several frame times; done from the last load holds.
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("break_err",  64'(upg_err_o),  64'd1);
    check("break_done", 64'(upg_done_o), 64'd1);

    // Reset in the middle of the second word.
    tx_q = '{8'h5A, 8'h02, 8'h00};
    repeat (5) tx_q.push_back(8'($urandom));
    exp_q.push_back({5'h00, tx_q[6], tx_q[5], tx_q[4], tx_q[3]});
    foreach (tx_q[k]) send_byte(tx_q[k], 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("midreset_outputs", 64'({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o}), 64'd0);
    check("midreset_first_word", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    random_load(1);

    // Index overflow: two words beyond the addressable range.
    random_load(LIM + 2);

`ifdef UPG_CHECKSUM_EN
    tx_q = '{8'h5A, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    exp_q.push_back({5'h00, 32'h44332211});
    run_load(1'b1, 1'b0);
    tx_q = '{8'h5A, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    exp_q.push_back({5'h00, 32'h44332211});
    run_load(1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
